// File: rtl/ucsbece154a_lsu_if.sv
// ---------------------------------------------------------------------------
// ucsbece154a_lsu_if
// Core-side request/response bundle of the load/store unit.
// Member names are written from the LSU's point of view (_i into the LSU,
// _o out of it) so they read the same inside the unit and on the bench.
//   req_valid_i     request present
//   req_ready_o     LSU can accept a request this cycle
//   req_we_i        1 = store, 0 = load
//   req_size_i      00 byte, 01 half, 10/11 word
//   req_unsigned_i  loads: 1 zero-extend, 0 sign-extend
//   req_addr_i      byte address
//   req_wdata_i     store data, right-justified
//   resp_valid_o    one-cycle completion pulse
//   resp_rdata_o    extended load data (0 for stores)
//   resp_err_o      misaligned-access flag
// Modports: slave = LSU side, master = core side.
// ---------------------------------------------------------------------------
interface ucsbece154a_lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i,
           req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i,
           req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/ucsbece154a_lsu.sv
// ---------------------------------------------------------------------------
// ucsbece154a_lsu
// Load/store unit: initiator side of a word-wide data memory with
// combinational read and rising-edge write. Byte/half/word loads are
// extracted per little-endian lane and sign/zero-extended; sub-word stores
// are done as read-modify-write (read in ACCESS, write in MERGE).
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      asynchronous, active-high
//   core       ucsbece154a_lsu_if.slave request/response bundle
//   dmem_we_o  memory write enable
//   dmem_a_o   memory byte address, word aligned, bits [31:DMEM_AW] zero
//   dmem_wd_o  memory write data
//   dmem_rd_i  memory read data (combinational from dmem_a_o)
//
// Parameter DMEM_AW : number of byte-address bits forwarded to memory.
//
// Optional macro UCSBECE154A_LSU_MISALIGN_TRAP_EN: when defined, a halfword
// access with addr[0]=1 or a word access with addr[1:0]!=0 skips the memory
// entirely and completes with resp_err_o=1. When undefined, resp_err_o is
// always 0 and the low address bits that do not select a lane are ignored.
// ---------------------------------------------------------------------------
module ucsbece154a_lsu #(
  parameter int DMEM_AW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  ucsbece154a_lsu_if.slave        core,
  output logic                    dmem_we_o,
  output logic [31:0]             dmem_a_o,
  output logic [31:0]             dmem_wd_o,
  input  logic [31:0]             dmem_rd_i
);

  // Keeps the forwarded byte-address bits and forces word alignment.
  localparam logic [31:0] ADDR_MASK = ((32'd1 << DMEM_AW) - 32'd1) & ~32'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  logic        misalign;
  logic        isWord;
  logic        isHalf;
  logic [31:0] wordAddr;
  logic [4:0]  byteShift;
  logic [4:0]  halfShift;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadData;
  logic [31:0] mergeData;

`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
  // Evaluated on the incoming request so a trapped access never touches memory.
  assign misalign = ((core.req_size_i == 2'b01) && core.req_addr_i[0]) ||
                    (core.req_size_i[1] && (core.req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Size code 11 behaves as a word.
  assign isWord    = size_q[1];
  assign isHalf    = (size_q == 2'b01);
  assign wordAddr  = addr_q & ADDR_MASK;
  assign byteShift = {addr_q[1:0], 3'b000};
  assign halfShift = {addr_q[1], 4'b0000};
  assign laneByte  = word_q[byteShift +: 8];
  assign laneHalf  = word_q[halfShift +: 16];

  // Lane extraction and extension for loads, from the word captured in ACCESS.
  always_comb begin
    loadData = word_q;
    if (!isWord) begin
      if (isHalf) begin
        loadData = {{16{laneHalf[15] & ~unsigned_q}}, laneHalf};
      end else begin
        loadData = {{24{laneByte[7] & ~unsigned_q}}, laneByte};
      end
    end
  end

  // Read-modify-write merge: only the addressed lane(s) take store data.
  always_comb begin
    mergeData = word_q;
    if (isHalf) begin
      mergeData[halfShift +: 16] = wdata_q[15:0];
    end else begin
      mergeData[byteShift +: 8] = wdata_q[7:0];
    end
  end

  // Next-state and output logic. Outputs depend on state only, so an
  // asynchronous reset drops dmem_we_o immediately.
  always_comb begin
    state_d           = state_q;
    we_d              = we_q;
    size_d            = size_q;
    unsigned_d        = unsigned_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    word_d            = word_q;
    err_d             = err_q;
    core.req_ready_o  = 1'b0;
    core.resp_valid_o = 1'b0;
    core.resp_rdata_o = 32'd0;
    core.resp_err_o   = 1'b0;
    dmem_we_o         = 1'b0;
    dmem_a_o          = 32'd0;
    dmem_wd_o         = 32'd0;

    unique case (state_q)
      IDLE: begin
        core.req_ready_o = 1'b1;
        if (core.req_valid_i) begin
          we_d       = core.req_we_i;
          size_d     = core.req_size_i;
          unsigned_d = core.req_unsigned_i;
          addr_d     = core.req_addr_i;
          wdata_d    = core.req_wdata_i;
          word_d     = 32'd0;
          err_d      = misalign;
          state_d    = misalign ? RESP : ACCESS;
        end
      end

      ACCESS: begin
        dmem_a_o = wordAddr;
        if (we_q && isWord) begin
          dmem_we_o = 1'b1;
          dmem_wd_o = wdata_q;
          state_d   = RESP;
        end else begin
          word_d  = dmem_rd_i;
          state_d = we_q ? MERGE : RESP;
        end
      end

      MERGE: begin
        dmem_a_o  = wordAddr;
        dmem_we_o = 1'b1;
        dmem_wd_o = mergeData;
        state_d   = RESP;
      end

      RESP: begin
        core.resp_valid_o = 1'b1;
        core.resp_rdata_o = (we_q || err_q) ? 32'd0 : loadData;
        core.resp_err_o   = err_q;
        state_d           = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      word_q     <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ucsbece154a_lsu.sv
// ---------------------------------------------------------------------------
// tb_ucsbece154a_lsu
// Directed bench for ucsbece154a_lsu: a 64-word data memory model with
// combinational read and rising-edge write sits on the dmem port, and
// hand-computed expected values are compared through checkOutput.
// Latency is counted in rising edges starting with the edge that ends the
// cycle in which the request is accepted (that edge counts as 1).
// ---------------------------------------------------------------------------
module tb_ucsbece154a_lsu;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ucsbece154a_lsu_if coreBus();

  logic        dmemWe;
  logic [31:0] dmemA;
  logic [31:0] dmemWd;
  logic [31:0] dmemRd;

  ucsbece154a_lsu #(.DMEM_AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .core      (coreBus),
    .dmem_we_o (dmemWe),
    .dmem_a_o  (dmemA),
    .dmem_wd_o (dmemWd),
    .dmem_rd_i (dmemRd)
  );

  // Memory model plus write monitor; preload writes share the same process.
  logic [31:0] mem [0:63];
  logic        preloadEn = 1'b0;
  logic [5:0]  preloadIdx = 6'd0;
  logic [31:0] preloadData = 32'd0;
  int          weCount = 0;
  logic [31:0] lastWeAddr = 32'd0;
  logic [31:0] lastWeData = 32'd0;
  int          respCount = 0;

  assign dmemRd = mem[dmemA[7:2]];

  always @(posedge clk) begin
    if (dmemWe) begin
      mem[dmemA[7:2]] <= dmemWd;
      weCount         <= weCount + 1;
      lastWeAddr      <= dmemA;
      lastWeData      <= dmemWd;
    end else if (preloadEn) begin
      mem[preloadIdx] <= preloadData;
    end
  end

  always @(negedge clk) begin
    if (coreBus.resp_valid_o) respCount <= respCount + 1;
  end

  int vectorCount = 0;
  int miscompareCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    preloadIdx  = idx;
    preloadData = data;
    preloadEn   = 1'b1;
    tick();
    preloadEn   = 1'b0;
  endtask

  // Presents a request and holds it until the accepting edge has passed.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bit accepted;
    accepted                = 1'b0;
    coreBus.req_we_i        = we;
    coreBus.req_size_i      = size;
    coreBus.req_unsigned_i  = uns;
    coreBus.req_addr_i      = addr;
    coreBus.req_wdata_i     = wdata;
    coreBus.req_valid_i     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (coreBus.req_ready_o) begin
        accepted = 1'b1;
        tick();
        break;
      end
      tick();
    end
    coreBus.req_valid_i = 1'b0;
    if (!accepted) checkOutput("accept timeout", 32'd0, 32'd1);
  endtask

  // Waits for the response pulse, returns its latency and payload, and
  // checks that it lasts one cycle with no memory write alongside it.
  task automatic waitResp(input string tag, output int lat, output logic [31:0] data,
                          output logic err);
    lat  = 0;
    data = 32'd0;
    err  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (coreBus.resp_valid_o) begin
        lat  = k;
        data = coreBus.resp_rdata_o;
        err  = coreBus.resp_err_o;
        break;
      end
      tick();
    end
    if (lat == 0) begin
      checkOutput({tag, " resp timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, " we in resp"}, {31'd0, dmemWe}, 32'd0);
      tick();
      checkOutput({tag, " resp one cycle"}, {31'd0, coreBus.resp_valid_o}, 32'd0);
    end
  endtask

  task automatic doLoad(input string tag, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] expected);
    int          lat;
    logic [31:0] data;
    logic        err;
    applyStimulus(1'b0, size, uns, addr, 32'd0);
    waitResp(tag, lat, data, err);
    checkOutput({tag, " data"}, data, expected);
    checkOutput({tag, " lat"}, lat, 32'd2);
  endtask

  int          lat;
  logic [31:0] data;
  logic        err;
  int          w0;
  int          r0;
  int          accepts;
  int          notReady;
  int          prevAcc;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset                  = 1'b1;
    coreBus.req_valid_i    = 1'b0;
    coreBus.req_we_i       = 1'b0;
    coreBus.req_size_i     = 2'b00;
    coreBus.req_unsigned_i = 1'b0;
    coreBus.req_addr_i     = 32'd0;
    coreBus.req_wdata_i    = 32'd0;
    repeat (2) tick();

    $display("[TB] reset values");
    checkOutput("reset ready", {31'd0, coreBus.req_ready_o}, 32'd1);
    checkOutput("reset resp_valid", {31'd0, coreBus.resp_valid_o}, 32'd0);
    checkOutput("reset rdata", coreBus.resp_rdata_o, 32'd0);
    checkOutput("reset err", {31'd0, coreBus.resp_err_o}, 32'd0);
    checkOutput("reset dmem_we", {31'd0, dmemWe}, 32'd0);
    checkOutput("reset dmem_a", dmemA, 32'd0);
    checkOutput("reset dmem_wd", dmemWd, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] word store / word load");
    w0 = weCount;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    waitResp("sw", lat, data, err);
    checkOutput("sw lat", lat, 32'd2);
    checkOutput("sw rdata", data, 32'd0);
    checkOutput("sw we pulses", weCount - w0, 32'd1);
    checkOutput("sw we addr", lastWeAddr, 32'h10);
    checkOutput("sw mem", mem[4], 32'hDEADBEEF);
    doLoad("lw 0x10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

    $display("[TB] sub-word stores");
    preload(6'd8, 32'h11223344);
    w0 = weCount;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AB);
    checkOutput("sb read cycle we", {31'd0, dmemWe}, 32'd0);
    checkOutput("sb read cycle addr", dmemA, 32'h20);
    waitResp("sb", lat, data, err);
    checkOutput("sb lat", lat, 32'd3);
    checkOutput("sb we pulses", weCount - w0, 32'd1);
    checkOutput("sb wd", lastWeData, 32'h11AB3344);
    checkOutput("sb we addr", lastWeAddr, 32'h20);
    checkOutput("sb mem", mem[8], 32'h11AB3344);

    applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
    waitResp("sh", lat, data, err);
    checkOutput("sh lat", lat, 32'd3);
    checkOutput("sh mem", mem[8], 32'hBEEF3344);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'h23, 32'hFFFFFFC3);
    waitResp("sb hi", lat, data, err);
    checkOutput("sb hi mem", mem[8], 32'hC3EF3344);

    $display("[TB] sub-word loads");
    preload(6'd12, 32'h80FF7F01);
    doLoad("lb 0x31 s", 2'b00, 1'b0, 32'h31, 32'h0000007F);
    doLoad("lb 0x32 s", 2'b00, 1'b0, 32'h32, 32'hFFFFFFFF);
    doLoad("lh 0x32 s", 2'b01, 1'b0, 32'h32, 32'hFFFF80FF);
    doLoad("lh 0x32 u", 2'b01, 1'b1, 32'h32, 32'h000080FF);
    doLoad("lb 0x33 u", 2'b00, 1'b1, 32'h33, 32'h00000080);
    doLoad("lh 0x30 s", 2'b01, 1'b0, 32'h30, 32'h00007F01);
    doLoad("lw sz11", 2'b11, 1'b0, 32'h30, 32'h80FF7F01);

    $display("[TB] reset during merge");
    preload(6'd16, 32'h55555555);
    w0 = weCount;
    r0 = respCount;
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h40, 32'h00001234);
    tick();
    checkOutput("merge we", {31'd0, dmemWe}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst mid we", {31'd0, dmemWe}, 32'd0);
    checkOutput("rst mid ready", {31'd0, coreBus.req_ready_o}, 32'd1);
    checkOutput("rst mid resp", {31'd0, coreBus.resp_valid_o}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("rst mid mem", mem[16], 32'h55555555);
    checkOutput("rst mid we pulses", weCount - w0, 32'd0);
    checkOutput("rst mid resp count", respCount - r0, 32'd0);
    checkOutput("rst mid idle ready", {31'd0, coreBus.req_ready_o}, 32'd1);

    $display("[TB] back-to-back requests");
    r0       = respCount;
    accepts  = 0;
    notReady = 0;
    prevAcc  = -1;
    coreBus.req_we_i       = 1'b0;
    coreBus.req_size_i     = 2'b10;
    coreBus.req_unsigned_i = 1'b0;
    coreBus.req_addr_i     = 32'h10;
    coreBus.req_valid_i    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (coreBus.req_ready_o) begin
        accepts++;
        if (prevAcc >= 0) checkOutput("accept spacing", c - prevAcc, 32'd3);
        prevAcc = c;
      end else begin
        notReady++;
      end
      tick();
    end
    coreBus.req_valid_i = 1'b0;
    repeat (4) tick();
    checkOutput("stream accepts", accepts, 32'd4);
    checkOutput("stream not ready", notReady, 32'd6);
    checkOutput("stream responses", respCount - r0, 32'd4);

    $display("[TB] misaligned word load");
    w0 = weCount;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'd0);
    waitResp("lw 0x13", lat, data, err);
`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
    checkOutput("misalign err", {31'd0, err}, 32'd1);
    checkOutput("misalign rdata", data, 32'd0);
    checkOutput("misalign lat", lat, 32'd1);
`else
    checkOutput("misalign err", {31'd0, err}, 32'd0);
    checkOutput("misalign rdata", data, 32'hDEADBEEF);
    checkOutput("misalign lat", lat, 32'd2);
`endif
    checkOutput("misalign we pulses", weCount - w0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
